// File: rtl/freq_meter_pkg.sv
// Shared state encoding and default parameters for the reciprocal frequency meter.
package freq_meter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_DONE} state_t;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_GATE_CYC    = 50_000_000;
  localparam int DEF_TIMEOUT_CYC = 100_000_000;
  localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/fx_sync_edge.sv
// Brings the asynchronous fx pin into sysclk and emits a one-cycle pulse per rising edge.
module fx_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic sysclk,
  input  logic reset,
  input  logic i_fx,
  output logic o_edge
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_edge;

  // Registered edge output gives a fixed STAGES+1 cycle lag from the pin.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_fx};
      r_prev <= r_sync[STAGES-1];
      r_edge <= r_sync[STAGES-1] & ~r_prev;
    end
  end

  assign o_edge = r_edge;
endmodule

// File: rtl/freq_meter_eqp.sv
// Equal-precision (reciprocal) frequency meter: gate aligned to whole fx periods,
// results read out bytewise, irq/ovf/tmo status.
module freq_meter_eqp
  import freq_meter_pkg::*;
#(
  parameter  int CNT_W       = DEF_CNT_W,
  parameter  int GATE_CYC    = DEF_GATE_CYC,
  parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int SEL_W       = $clog2(2*CNT_W/8)
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             fx,
  input  logic             start,
  input  logic             mode_cont,
  input  logic [SEL_W-1:0] sel,
  output logic [7:0]       data_out,
  output logic             irq,
  input  logic             ack,
  output logic             busy,
  output logic             ovf,
  output logic             tmo
);
  localparam int          NB     = CNT_W/8;
  localparam int          TMR_W  = $clog2(TIMEOUT_CYC+1);
  localparam logic [63:0] GATE_L = 64'(GATE_CYC);

  state_t             r_state;
  logic [CNT_W-1:0]   r_fx_cnt, r_base_cnt, r_fx_res, r_base_res;
  logic [TMR_W-1:0]   r_tmr;
  logic               r_rearm, r_ovf_p, r_tmo_p, r_irq, r_ovf, r_tmo;
  logic [7:0]         r_dout, w_byte;
  logic               w_edge, w_gate, w_sat, w_tmo_hit;

  fx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .sysclk (sysclk),
    .reset  (reset),
    .i_fx   (fx),
    .o_edge (w_edge)
  );

  // 64-bit compare so GATE_CYC may exceed the counter range (saturation wins then).
  assign w_gate    = w_edge && ((64'(r_base_cnt) + 64'd1) >= GATE_L);
  assign w_sat     = (&r_base_cnt) | (&r_fx_cnt);
  assign w_tmo_hit = !w_edge && (r_tmr == TMR_W'(TIMEOUT_CYC-1));

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fx_cnt   <= '0;
      r_base_cnt <= '0;
      r_fx_res   <= '0;
      r_base_res <= '0;
      r_tmr      <= '0;
      r_rearm    <= 1'b0;
      r_ovf_p    <= 1'b0;
      r_tmo_p    <= 1'b0;
      r_irq      <= 1'b0;
      r_ovf      <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      if (ack) r_irq <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tmr   <= '0;
          r_rearm <= 1'b0;
          if (start || (mode_cont && r_rearm)) r_state <= S_ARM;
        end
        S_ARM: begin
          if (w_edge) begin
            r_fx_cnt   <= '0;
            r_base_cnt <= '0;
            r_tmr      <= '0;
            r_state    <= S_MEAS;
          end else if (w_tmo_hit) begin
            r_fx_res   <= '0;
            r_base_res <= '0;
            r_ovf_p    <= 1'b0;
            r_tmo_p    <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_MEAS: begin
          if (w_sat) begin
            r_fx_res   <= '1;
            r_base_res <= '1;
            r_ovf_p    <= 1'b1;
            r_tmo_p    <= 1'b0;
            r_state    <= S_DONE;
          end else if (w_gate) begin
            r_fx_res   <= r_fx_cnt + 1'b1;
            r_base_res <= r_base_cnt + 1'b1;
            r_ovf_p    <= 1'b0;
            r_tmo_p    <= 1'b0;
            r_state    <= S_DONE;
          end else if (w_tmo_hit) begin
            r_fx_res   <= '0;
            r_base_res <= '0;
            r_ovf_p    <= 1'b0;
            r_tmo_p    <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_base_cnt <= r_base_cnt + 1'b1;
            if (w_edge) begin
              r_fx_cnt <= r_fx_cnt + 1'b1;
              r_tmr    <= '0;
            end else begin
              r_tmr <= r_tmr + 1'b1;
            end
          end
        end
        S_DONE: begin
          // Set after the ack clear above, so a coincident ack cannot drop irq.
          r_irq   <= 1'b1;
          r_ovf   <= r_ovf_p;
          r_tmo   <= r_tmo_p;
          r_rearm <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_byte = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (sel == SEL_W'(i))      w_byte = r_fx_res[8*i +: 8];
      if (sel == SEL_W'(i + NB)) w_byte = r_base_res[8*i +: 8];
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) r_dout <= 8'h00;
    else       r_dout <= w_byte;
  end

  assign data_out = r_dout;
  assign irq      = r_irq;
  assign ovf      = r_ovf;
  assign tmo      = r_tmo;
  assign busy     = (r_state == S_ARM) || (r_state == S_MEAS);
endmodule

// File: tb/tb_freq_meter_eqp.sv
// Randomized bench for freq_meter_eqp against a period/gate arithmetic model.
module tb_freq_meter_eqp;
  localparam int G = 100;
  localparam int T = 400;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1, fx = 1'b0, start = 1'b0, start2 = 1'b0;
  logic       mode_cont = 1'b0, mode_cont2 = 1'b0, ack = 1'b0, ack2 = 1'b0;
  logic [2:0] sel = '0;
  logic [1:0] sel2 = '0;
  logic [7:0] dout, dout2;
  logic       irq, busy, ovf, tmo, irq2, busy2, ovf2, tmo2;
  int         n_cmp = 0, n_bad = 0;
  int         per = 0, hi = 1;

  always #5 sysclk = ~sysclk;

  freq_meter_eqp #(.CNT_W(32), .GATE_CYC(G), .TIMEOUT_CYC(T), .SYNC_STAGES(2)) u_dut (
    .sysclk(sysclk), .reset(reset), .fx(fx), .start(start), .mode_cont(mode_cont),
    .sel(sel), .data_out(dout), .irq(irq), .ack(ack), .busy(busy), .ovf(ovf), .tmo(tmo));

  freq_meter_eqp #(.CNT_W(16), .GATE_CYC(70000), .TIMEOUT_CYC(T), .SYNC_STAGES(3)) u_dut16 (
    .sysclk(sysclk), .reset(reset), .fx(fx), .start(start2), .mode_cont(mode_cont2),
    .sel(sel2), .data_out(dout2), .irq(irq2), .ack(ack2), .busy(busy2), .ovf(ovf2), .tmo(tmo2));

  // fx source: period per (0 = held low), high for hi cycles
  initial begin
    forever begin
      if (per == 0) begin
        fx = 1'b0;
        @(negedge sysclk);
      end else begin
        fx = 1'b1;
        repeat (hi) @(negedge sysclk);
        fx = 1'b0;
        repeat (per - hi) @(negedge sysclk);
      end
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic pulse_start(input int w);
    if (w == 0) start = 1'b1; else start2 = 1'b1;
    tick(1);
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_irq(input int w, input int lim);
    for (int i = 0; i < lim; i++) begin
      if ((w == 0) ? irq : irq2) break;
      tick(1);
    end
    chk("irq_wait", longint'((w == 0) ? irq : irq2), 1);
  endtask

  task automatic wait_done(input int lim);
    int i;
    for (i = 0; i < lim && !busy; i++) tick(1);
    for (i = 0; i < lim && busy; i++) tick(1);
    chk("done_wait", longint'(busy), 0);
  endtask

  // Whole fx periods until the gate is met; saturates when the span exceeds the counter.
  task automatic model(input int p, input int g, input int w, output longint f,
                       output longint b, output longint ov, output longint tm);
    longint k, lim;
    lim = (longint'(1) << w) - 1;
    if (p == 0) begin
      f = 0; b = 0; ov = 0; tm = 1;
    end else begin
      k = (g + p - 1) / p;
      b = k * p; f = k; ov = 0; tm = 0;
      if (b > lim) begin f = lim; b = lim; ov = 1; end
    end
  endtask

  task automatic rd_res(input int w, output longint f, output longint b);
    int nb;
    longint v;
    nb = (w == 0) ? 4 : 2;
    f = 0; b = 0;
    for (int i = 0; i < 2*nb; i++) begin
      if (w == 0) sel = 3'(i); else sel2 = 2'(i);
      tick(1);
      v = longint'((w == 0) ? dout : dout2);
      if (i < nb) f |= v << (8*i);
      else        b |= v << (8*(i - nb));
    end
  endtask

  task automatic check_res(input int p, input string tag);
    longint ef, eb, eo, et, f, b;
    model(p, G, 32, ef, eb, eo, et);
    rd_res(0, f, b);
    chk({tag, "_fx_res"}, f, ef);
    chk({tag, "_base_res"}, b, eb);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_tmo"}, tmo, et);
  endtask

  task automatic run_one(input int p, input int h, input string tag);
    per = p; hi = h;
    tick(4*p + 20);
    pulse_start(0);
    tick($urandom_range(3, 20));
    pulse_start(0);
    wait_irq(0, 3000);
    check_res(p, tag);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk({tag, "_irq_clr"}, irq, 0);
  endtask

  initial begin
    longint f, b, ef, eb, eo, et;
    int     cnt, p;

    tick(6);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_dout", dout, 0);
    chk("rst_irq16", irq2, 0);
    reset = 1'b0;
    tick(2);

    run_one(10, 5, "p10");
    run_one(7, 3, "p7");

    // readout latency: the new byte only appears after a clock edge
    sel = 3'd0;
    tick(1);
    sel = 3'd4;
    chk("sel_hold", dout, 15);
    tick(1);
    chk("sel_new", dout, 105);

    // fx stuck low: timeout after exactly T cycles in ARM
    per = 0;
    tick(20);
    pulse_start(0);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (busy) cnt++;
      if (irq) break;
      tick(1);
    end
    chk("tmo_arm_cycles", cnt, T);
    chk("tmo_irq", irq, 1);
    check_res(0, "tmo");
    ack = 1'b1; tick(1); ack = 1'b0;

    for (int n = 0; n < 6; n++) begin
      p = $urandom_range(3, 45);
      run_one(p, $urandom_range(1, p - 1), $sformatf("rnd%0d_p%0d", n, p));
    end

    // continuous mode: ack coinciding with the second DONE keeps irq high
    per = 9; hi = 4;
    tick(60);
    mode_cont = 1'b1;
    pulse_start(0);
    wait_done(3000);
    tick(2);
    chk("cont1_irq", irq, 1);
    check_res(9, "cont1");
    wait_done(3000);
    chk("cont2_irq_pre", irq, 1);
    ack = 1'b1; mode_cont = 1'b0;
    tick(1);
    ack = 1'b0;
    chk("cont2_irq_ack_done", irq, 1);
    check_res(9, "cont2");
    chk("cont_stop_busy", busy, 0);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("cont_irq_clr", irq, 0);

    // reset mid-measurement with a prior result and irq pending
    per = 10; hi = 5;
    tick(50);
    pulse_start(0);
    wait_irq(0, 3000);
    pulse_start(0);
    tick(40);
    chk("mrst_busy_pre", busy, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_irq", irq, 0);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_tmo", tmo, 0);
    chk("mrst_dout", dout, 0);
    rd_res(0, f, b);
    chk("mrst_fx_res", f, 0);
    chk("mrst_base_res", b, 0);
    tick(300);
    chk("mrst_irq_later", irq, 0);
    chk("mrst_busy_later", busy, 0);

    // 16-bit instance with a gate beyond the counter range saturates
    pulse_start(1);
    wait_irq(1, 70000);
    model(10, 70000, 16, ef, eb, eo, et);
    rd_res(1, f, b);
    chk("sat_fx_res", f, ef);
    chk("sat_base_res", b, eb);
    chk("sat_ovf", ovf2, eo);
    chk("sat_tmo", tmo2, et);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/freq_meter_eqp.md
FREQ_METER_EQP -- requirements
Module: freq_meter_eqp

Interface
REQ-001 Parameter CNT_W, default 32: width of the fx and base result counters; SHALL be a multiple of 8, range 16..64.
REQ-002 Parameter GATE_CYC, default 50_000_000: minimum gate length in sysclk cycles.
REQ-003 Parameter TIMEOUT_CYC, default 100_000_000: maximum sysclk cycles to wait for an fx edge before the measurement is abandoned.
REQ-004 Parameter SYNC_STAGES, default 2: fx synchroniser depth, minimum 2.
REQ-005 Derived constant SEL_W = clog2(2*CNT_W/8): width of the byte-select address.
REQ-006 Port sysclk, input, 1: the only clock; all logic is on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port fx, input, 1: asynchronous signal under measurement.
REQ-009 Port start, input, 1: one-cycle pulse that requests a single measurement.
REQ-010 Port mode_cont, input, 1: when 1, a new measurement re-arms automatically after each DONE.
REQ-011 Port sel, input, SEL_W: byte address; low half selects fx_res bytes (LSB first), high half selects base_res bytes.
REQ-012 Port data_out, output, 8: registered byte selected by sel.
REQ-013 Port irq, output, 1: level, set when a result is latched.
REQ-014 Port ack, input, 1: one-cycle pulse that clears irq.
REQ-015 Port busy, output, 1: high in ARM and MEASURE.
REQ-016 Port ovf, output, 1: the last result saturated.
REQ-017 Port tmo, output, 1: the last measurement timed out.

Function
REQ-018 fx SHALL pass through SYNC_STAGES flops and then a rising-edge detector; the edge pulse (fx_edge) lags the fx pin by SYNC_STAGES+1 cycles.
REQ-019 FSM states SHALL be IDLE, ARM, MEASURE, DONE.
REQ-020 IDLE->ARM on start, or on mode_cont=1 one cycle after DONE.
REQ-021 ARM: on fx_edge SHALL go to MEASURE and clear fx_cnt, base_cnt and gate_tmr.
REQ-022 ARM: if TIMEOUT_CYC cycles pass with no fx_edge, SHALL go to DONE with fx_res=0, base_res=0, tmo=1.
REQ-023 MEASURE: base_cnt += 1 every cycle; fx_cnt += 1 on each fx_edge.
REQ-024 MEASURE: gate closes on the first fx_edge at which base_cnt+1 >= GATE_CYC; on that cycle fx_res <= fx_cnt+1 and base_res <= base_cnt+1, then go to DONE.
REQ-025 Result rule: fx_res = whole fx periods inside the gate; base_res = sysclk cycles across those periods; f_fx = fx_res*f_sysclk/base_res.
REQ-026 MEASURE: if base_cnt reaches all-ones, or fx_cnt reaches all-ones, SHALL latch both counters saturated, set ovf=1, and go to DONE.
REQ-027 MEASURE: if TIMEOUT_CYC cycles pass with no fx_edge, SHALL latch zeros, set tmo=1, and go to DONE.
REQ-028 DONE: irq, ovf and tmo SHALL update, then go to IDLE after one cycle; ovf and tmo hold until the next DONE.
REQ-029 start while busy SHALL be ignored.
REQ-030 ack SHALL clear irq; if ack and a new DONE fall in the same cycle, irq SHALL stay 1.
REQ-031 fx_res and base_res change only in DONE, so readout is always coherent.
REQ-032 data_out SHALL reflect sel one cycle later; unused sel codes SHALL read 0x00.

Reset
REQ-033 reset SHALL force state IDLE and clear all counters, fx_res, base_res, the synchroniser flops, data_out, irq, ovf and tmo to 0; busy goes to 0.
REQ-034 reset mid-measurement SHALL discard the measurement; no irq is raised.

Structure
REQ-035 Package freq_meter_pkg SHALL hold the state enum and the default parameter constants.
REQ-036 Sub-module fx_sync_edge (synchroniser plus edge detector) SHALL be the only sub-module; gate, counters, FSM and readout stay in freq_meter_eqp.

Verification
REQ-037 Use GATE_CYC=100 and TIMEOUT_CYC=400. fx period 10 cycles, start pulse -> irq=1; fx_res=10, base_res=100; ovf=0, tmo=0.
REQ-038 fx period 7 cycles -> fx_res=15, base_res=105; sel sweep returns bytes LSB-first with 1-cycle latency.
REQ-039 fx held low, then start -> tmo=1 after 400 cycles in ARM; results 0; irq=1.
REQ-040 CNT_W=16, GATE_CYC=70000, fx period 10 -> ovf=1, base_res=0xFFFF.
REQ-041 mode_cont=1 with ack pulsed on the same cycle as a DONE -> irq stays 1; back-to-back results match; reset in MEASURE -> all outputs 0 and no irq.
